// File: rtl/seq_div.sv
// Sequential restoring divider: 18-bit dividend by 9-bit divisor, one quotient bit per cycle.
// Optional SEQ_DIV_DIVZ_DETECT_EN: a zero divisor completes after one cycle and raises div_zero.
module seq_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] dividend,
  input  logic [8:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [17:0] quotient,
  output logic [8:0]  remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [17:0] work;
  logic [8:0]  dvs;
  logic [9:0]  part;
  logic [4:0]  step;
  logic [9:0]  shifted;
  logic [9:0]  part_next;
  logic        q_bit;
  logic        accept;
  logic        last_step;
  logic        zero_fast;

`ifdef SEQ_DIV_DIVZ_DETECT_EN
  assign zero_fast = (dvs == 9'd0);
`else
  assign zero_fast = 1'b0;
`endif

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign accept    = start && (state != RUN);
  assign last_step = (step == 5'd17);

  // The dividend register doubles as the quotient shift register: dividend bits
  // leave at the top while quotient bits enter at the bottom.
  always_comb begin
    shifted   = {part[8:0], work[17]};
    part_next = shifted;
    q_bit     = 1'b0;
    if (shifted >= {1'b0, dvs}) begin
      part_next = shifted - {1'b0, dvs};
      q_bit     = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step || zero_fast) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      dvs       <= '0;
      part      <= '0;
      step      <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        work <= dividend;
        dvs  <= divisor;
        part <= '0;
        step <= '0;
      end else if (state == RUN) begin
        if (zero_fast) begin
          quotient  <= 18'h3FFFF;
          remainder <= work[8:0];
          div_zero  <= 1'b1;
        end else begin
          work <= {work[16:0], q_bit};
          part <= part_next;
          step <= step + 5'd1;
          if (last_step) begin
            quotient  <= {work[16:0], q_bit};
            remainder <= part_next[8:0];
            div_zero  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
